// File: rtl/pid_pwm_multi.sv
// pid_pwm_multi: CH independent PID loops sharing one sequential arithmetic FSM,
// driving one heater PWM and one hysteresis fan output per channel.
// Optional derivative path: define PID_DERIV_EN to build the D term and per-channel e_prev.
module pid_pwm_multi #(
   parameter int unsigned CH       = 2,
   parameter int unsigned TW       = 12,
   parameter int unsigned KW       = 7,
   parameter int unsigned PERIOD   = 1000,
   parameter int unsigned SHIFT    = 4,
   parameter int unsigned IMAX     = 4095,
   parameter int unsigned FAN_HYST = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               pid_en_i,
   input  logic               pwm_tick_i,
   input  logic               sample_valid_i,
   input  logic [2:0]         sample_ch_i,
   input  logic [TW-1:0]      sample_temp_i,
   input  logic [CH*TW-1:0]   setpoint_i,
   input  logic [KW-1:0]      kp_i,
   input  logic [KW-1:0]      ki_i,
   input  logic [KW-1:0]      kd_i,
   output logic               busy_o,
   output logic               sample_drop_o,
   output logic [CH*16-1:0]   duty_o,
   output logic [CH-1:0]      heater_pwm_o,
   output logic [CH-1:0]      fan_on_o
);

   localparam int unsigned EW   = TW + 1;
   localparam int unsigned SW   = TW + KW + 12;
   localparam int unsigned IW   = $clog2(IMAX + 1) + 1;
   localparam int unsigned CNTW = $clog2(PERIOD);
   localparam int unsigned CHW  = (CH > 1) ? $clog2(CH) : 1;

   localparam logic [3:0]             CH_L     = 4'(CH);
   localparam logic [CNTW-1:0]        CNT_LAST = CNTW'(PERIOD - 1);
   localparam logic signed [SW-1:0]   IMAX_P   = SW'(IMAX);
   localparam logic signed [SW-1:0]   IMAX_N   = -IMAX_P;
   localparam logic signed [SW-1:0]   PERIOD_S = SW'(PERIOD);
   localparam logic signed [EW-1:0]   FAN_NEG  = EW'(-int'(FAN_HYST));

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ERR   = 3'd1,
      S_INTG  = 3'd2,
      S_MUL   = 3'd3,
      S_SUM   = 3'd4,
      S_CLAMP = 3'd5
   } state_t;

   state_t                 state_q, state_d;
   logic                   busy_q, busy_d;
   logic                   drop_q, drop_d;
   logic                   accept_c;
   logic                   ch_ok_c;

   logic [CHW-1:0]         ch_q;
   logic [TW-1:0]          temp_q;
   logic signed [EW-1:0]   e_q, e_c;
   logic signed [SW-1:0]   p_q, i_q, d_q, u_q;
   logic signed [SW-1:0]   p_c, i_c, d_c, sum_c;
   logic signed [SW-1:0]   isum_c, isat_c;
   logic [15:0]            clamp_c;

   logic [TW-1:0]          sp_c     [CH];
   logic signed [IW-1:0]   integ_q  [CH];
   logic [15:0]            shadow_q [CH];
   logic [15:0]            duty_q   [CH];
   logic [15:0]            duty_d   [CH];
   logic [CH-1:0]          fan_q;
   logic [CH-1:0]          heater_q, heater_d;

   logic [CNTW-1:0]        cnt_q, cnt_d;
   logic                   ticked_q, ticked_d;
   logic                   load_c;

`ifdef PID_DERIV_EN
   logic signed [EW-1:0]   eprev_q  [CH];
`else
   logic                   unused_kd;
   assign unused_kd = ^kd_i;
`endif

   // Per-channel setpoint unpacking and duty output packing
   for (genvar g = 0; g < int'(CH); g++) begin : g_ch
      assign sp_c[g]              = setpoint_i[g*TW +: TW];
      assign duty_o[g*16 +: 16]   = duty_q[g];
   end

   assign busy_o        = busy_q;
   assign sample_drop_o = drop_q;
   assign heater_pwm_o  = heater_q;
   assign fan_on_o      = fan_q;

   // FSM state and handshake flag registers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         drop_q  <= drop_d;
      end
   end

   // Next state, sample acceptance and drop decision
   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      drop_d   = 1'b0;
      accept_c = 1'b0;
      ch_ok_c  = ({1'b0, sample_ch_i} < CH_L);
      case (state_q)
         S_IDLE: begin
            if (sample_valid_i) begin
               if (ch_ok_c) begin
                  accept_c = 1'b1;
                  busy_d   = 1'b1;
                  state_d  = S_ERR;
               end else begin
                  drop_d = 1'b1;
               end
            end
         end
         S_ERR:   state_d = S_INTG;
         S_INTG:  state_d = S_MUL;
         S_MUL:   state_d = S_SUM;
         S_SUM:   state_d = S_CLAMP;
         S_CLAMP: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
      // anything offered outside IDLE (including the CLAMP cycle) is rejected
      if (sample_valid_i && (state_q != S_IDLE)) drop_d = 1'b1;
   end

   // Shared arithmetic for the channel currently in flight
   always_comb begin
      e_c    = $signed({1'b0, sp_c[ch_q]}) - $signed({1'b0, temp_q});
      isum_c = SW'(integ_q[ch_q]) + SW'(e_q);
      if (isum_c > IMAX_P)      isat_c = IMAX_P;
      else if (isum_c < IMAX_N) isat_c = IMAX_N;
      else                      isat_c = isum_c;
      p_c = SW'($signed({1'b0, kp_i})) * SW'(e_q);
      i_c = SW'($signed({1'b0, ki_i})) * SW'(integ_q[ch_q]);
`ifdef PID_DERIV_EN
      d_c = SW'($signed({1'b0, kd_i})) * (SW'(e_q) - SW'(eprev_q[ch_q]));
`else
      d_c = '0;
`endif
      sum_c = (p_q + i_q + d_q) >>> SHIFT;
      if (u_q[SW-1])            clamp_c = 16'd0;
      else if (u_q > PERIOD_S)  clamp_c = 16'(PERIOD);
      else                      clamp_c = 16'(u_q);
   end

   // Pipeline registers: sample latch, error, products, scaled sum
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ch_q   <= '0;
         temp_q <= '0;
         e_q    <= '0;
         p_q    <= '0;
         i_q    <= '0;
         d_q    <= '0;
         u_q    <= '0;
      end else begin
         if (accept_c) begin
            ch_q   <= CHW'(sample_ch_i);
            temp_q <= sample_temp_i;
         end
         if (state_q == S_ERR) e_q <= e_c;
         if (state_q == S_MUL) begin
            p_q <= p_c;
            i_q <= i_c;
            d_q <= d_c;
         end
         if (state_q == S_SUM) u_q <= sum_c;
      end
   end

   // Per-channel integrator, shadow duty and fan hysteresis
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int unsigned c = 0; c < CH; c++) begin
            integ_q[c]  <= '0;
            shadow_q[c] <= '0;
         end
         fan_q <= '0;
      end else begin
         for (int unsigned c = 0; c < CH; c++) begin
            if (!pid_en_i) begin
               integ_q[c]  <= '0;
               shadow_q[c] <= '0;
            end else if (ch_q == CHW'(c)) begin
               if (state_q == S_INTG)  integ_q[c]  <= IW'(isat_c);
               if (state_q == S_CLAMP) shadow_q[c] <= clamp_c;
            end
            if ((state_q == S_CLAMP) && (ch_q == CHW'(c))) begin
               if (e_q < FAN_NEG)    fan_q[c] <= 1'b1;
               else if (!e_q[EW-1])  fan_q[c] <= 1'b0;
            end
         end
      end
   end

`ifdef PID_DERIV_EN
   // Previous error per channel for the derivative term
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int unsigned c = 0; c < CH; c++) eprev_q[c] <= '0;
      end else begin
         for (int unsigned c = 0; c < CH; c++) begin
            if ((state_q == S_CLAMP) && (ch_q == CHW'(c))) eprev_q[c] <= e_q;
         end
      end
   end
`endif

   // PWM counter, period-boundary duty load and heater compare
   always_comb begin
      cnt_d    = cnt_q;
      load_c   = 1'b0;
      ticked_d = ticked_q | pwm_tick_i;
      if (pwm_tick_i) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            load_c = 1'b1;
         end else begin
            cnt_d = cnt_q + CNTW'(1);
         end
      end else if ((cnt_q == '0) && !ticked_q) begin
         // before the first tick after reset the period start is open-ended
         load_c = 1'b1;
      end
      for (int unsigned c = 0; c < CH; c++) begin
         duty_d[c]   = duty_q[c];
         if (!pid_en_i)   duty_d[c] = 16'd0;
         else if (load_c) duty_d[c] = shadow_q[c];
         heater_d[c] = pid_en_i & (16'(cnt_d) < duty_d[c]);
      end
   end

   // PWM state registers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         ticked_q <= 1'b0;
         heater_q <= '0;
         for (int unsigned c = 0; c < CH; c++) duty_q[c] <= '0;
      end else begin
         cnt_q    <= cnt_d;
         ticked_q <= ticked_d;
         heater_q <= heater_d;
         for (int unsigned c = 0; c < CH; c++) duty_q[c] <= duty_d[c];
      end
   end

endmodule

// File: tb/tb_pid_pwm_multi.sv
// Bench for pid_pwm_multi: sample-level behavioural model plus directed vectors.
module tb_pid_pwm_multi;

   localparam int CH     = 2;
   localparam int TW     = 12;
   localparam int PERIOD = 1000;
   localparam int DIV    = 16;
   localparam int IMAX   = 4095;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              pid_en = 1'b0;
   logic              pwm_tick = 1'b0;
   logic              sample_valid = 1'b0;
   logic [2:0]        sample_ch = '0;
   logic [TW-1:0]     sample_temp = '0;
   logic [CH*TW-1:0]  setpoint = '0;
   logic [6:0]        kp = '0, ki = '0, kd = '0;
   logic              busy, sample_drop;
   logic [CH*16-1:0]  duty;
   logic [CH-1:0]     heater_pwm, fan_on;

   always #5 clk = ~clk;

   pid_pwm_multi dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .pid_en_i       (pid_en),
      .pwm_tick_i     (pwm_tick),
      .sample_valid_i (sample_valid),
      .sample_ch_i    (sample_ch),
      .sample_temp_i  (sample_temp),
      .setpoint_i     (setpoint),
      .kp_i           (kp),
      .ki_i           (ki),
      .kd_i           (kd),
      .busy_o         (busy),
      .sample_drop_o  (sample_drop),
      .duty_o         (duty),
      .heater_pwm_o   (heater_pwm),
      .fan_on_o       (fan_on)
   );

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   longint m_integ [CH];
   longint m_eprev [CH];
   longint m_shadow[CH];
   longint m_duty  [CH];
   longint old_sh  [CH];
   bit     m_fan   [CH];
   bit     m_heat  [CH];
   int     m_cnt, m_left, m_ch, m_temp;
   bit     m_ticked, m_busy, m_drop, ld;

   // full PID evaluation of one sample, applied at its completion
   task automatic finish_sample();
      longint e, p, i, d, s, u;
      e = longint'(setpoint[m_ch*TW +: TW]) - longint'(m_temp);
      if (pid_en) begin
         m_integ[m_ch] = m_integ[m_ch] + e;
         if (m_integ[m_ch] > IMAX)  m_integ[m_ch] = IMAX;
         if (m_integ[m_ch] < -IMAX) m_integ[m_ch] = -IMAX;
      end else begin
         m_integ[m_ch] = 0;
      end
      p = longint'(kp) * e;
      i = longint'(ki) * m_integ[m_ch];
`ifdef PID_DERIV_EN
      d = longint'(kd) * (e - m_eprev[m_ch]);
`else
      d = 0;
`endif
      s = p + i + d;
      u = (s >= 0) ? s / DIV : -((-s + DIV - 1) / DIV);
      if (!pid_en)         m_shadow[m_ch] = 0;
      else if (u < 0)      m_shadow[m_ch] = 0;
      else if (u > PERIOD) m_shadow[m_ch] = PERIOD;
      else                 m_shadow[m_ch] = u;
      m_eprev[m_ch] = e;
      if (e < -16)     m_fan[m_ch] = 1'b1;
      else if (e >= 0) m_fan[m_ch] = 1'b0;
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int c = 0; c < CH; c++) begin
            m_integ[c] = 0; m_eprev[c] = 0; m_shadow[c] = 0;
            m_duty[c] = 0;  m_fan[c] = 1'b0; m_heat[c] = 1'b0;
         end
         m_cnt = 0; m_left = 0; m_ticked = 1'b0; m_busy = 1'b0; m_drop = 1'b0;
      end else begin
         for (int c = 0; c < CH; c++) old_sh[c] = m_shadow[c];
         ld = 1'b0;
         if (pwm_tick) begin
            if (m_cnt == PERIOD - 1) begin m_cnt = 0; ld = 1'b1; end
            else m_cnt++;
            m_ticked = 1'b1;
         end else if (m_cnt == 0 && !m_ticked) begin
            ld = 1'b1;
         end
         if (ld) for (int c = 0; c < CH; c++) m_duty[c] = old_sh[c];
         m_drop = 1'b0;
         if (m_left > 0) begin
            if (sample_valid) m_drop = 1'b1;
            m_left--;
            if (m_left == 0) finish_sample();
         end else if (sample_valid) begin
            if (int'(sample_ch) < CH) begin
               m_left = 5; m_ch = int'(sample_ch); m_temp = int'(sample_temp);
            end else begin
               m_drop = 1'b1;
            end
         end
         if (!pid_en) begin
            for (int c = 0; c < CH; c++) begin
               m_integ[c] = 0; m_shadow[c] = 0; m_duty[c] = 0;
            end
         end
         for (int c = 0; c < CH; c++) m_heat[c] = pid_en && (m_cnt < m_duty[c]);
         m_busy = (m_left > 0);
      end
   end

   // ---------------- per-cycle comparison ----------------
   logic [CH*16-1:0] exp_duty;
   logic [CH-1:0]    exp_heat, exp_fan;

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int c = 0; c < CH; c++) begin
            exp_duty[c*16 +: 16] = 16'(m_duty[c]);
            exp_heat[c]          = m_heat[c];
            exp_fan[c]           = m_fan[c];
         end
         chk("busy", busy, m_busy);
         chk("sample_drop", sample_drop, m_drop);
         chk("duty", duty, exp_duty);
         chk("heater_pwm", heater_pwm, exp_heat);
         chk("fan_on", fan_on, exp_fan);
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_sp(input int sp0, input int sp1);
      setpoint = {12'(sp1), 12'(sp0)};
   endtask

   task automatic send(input int ch, input int temp);
      sample_ch    = 3'(ch);
      sample_temp  = 12'(temp);
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   int n, hi;

   initial begin
      // 1: reset with random inputs
      @(negedge clk);
      cmp_en = 1'b1;
      repeat (3) begin
         pid_en       = 1'($urandom);
         pwm_tick     = 1'($urandom);
         sample_valid = 1'($urandom);
         sample_ch    = 3'($urandom);
         sample_temp  = 12'($urandom);
         setpoint     = 24'($urandom);
         kp = 7'($urandom); ki = 7'($urandom); kd = 7'($urandom);
         @(negedge clk);
      end
      chk("rst_busy", busy, 0);
      chk("rst_drop", sample_drop, 0);
      chk("rst_duty", duty, 0);
      chk("rst_heater", heater_pwm, 0);
      chk("rst_fan", fan_on, 0);
      pid_en = 1'b1; pwm_tick = 1'b0; sample_valid = 1'b0;
      kp = 7'd0; ki = 7'd1; kd = 7'd0;
      set_sp(1600, 400);
      rst_n = 1'b1;
      @(negedge clk);

      // reset mid-computation discards the sample
      sample_ch = 3'd0; sample_temp = 12'd0; sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_busy", busy, 0);
      repeat (6) @(negedge clk);
      chk("midrst_duty0", duty[15:0], 0);

      // 4: integrator saturation (duty follows shadow before first tick)
      send(0, 0);    chk("t4_s1", duty[15:0], 100);
      send(0, 0);    chk("t4_s2", duty[15:0], 200);
      send(0, 0);    chk("t4_s3", duty[15:0], 255);
      send(0, 0);    chk("t4_s4", duty[15:0], 255);
      send(0, 0);    chk("t4_s5", duty[15:0], 255);
      send(0, 1700); chk("t4_neg", duty[15:0], 249);
      chk("t4_fan0", fan_on[0], 1);

      // 5: back-to-back rejection and bad channel
      sample_ch = 3'd0; sample_temp = 12'd1600; sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      @(negedge clk);
      sample_temp = 12'd0; sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      chk("t5_drop_b2b", sample_drop, 1);
      repeat (5) @(negedge clk);
      chk("t5_integ_kept", duty[15:0], 249);
      chk("t5_fan0_clr", fan_on[0], 0);
      sample_ch = 3'd5; sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      chk("t5_drop_ch", sample_drop, 1);
      chk("t5_busy_ch", busy, 0);
      repeat (2) @(negedge clk);

      // 6: fan hysteresis on ch1, then derivative kick
      ki = 7'd0;
      send(1, 417); chk("t6_fan_on", fan_on[1], 1);
      send(1, 405); chk("t6_fan_hold", fan_on[1], 1);
      send(1, 400); chk("t6_fan_off", fan_on[1], 0);
      kd = 7'd8;
      send(1, 384);
`ifdef PID_DERIV_EN
      chk("t6_d_pos", duty[31:16], 8);
`else
      chk("t6_d_pos", duty[31:16], 0);
`endif
      send(1, 400); chk("t6_d_neg", duty[31:16], 0);
      kd = 7'd0;

      // pid_en low forces duty and heater off immediately
      pid_en = 1'b0;
      @(negedge clk);
      chk("en_off_duty", duty, 0);
      chk("en_off_heater", heater_pwm, 0);

      // 2: proportional only, glitch-free load at wrap
      pwm_tick = 1'b1;
      pid_en = 1'b1; kp = 7'd16;
      set_sp(400, 400);
      send(0, 384);
      chk("t2_no_early_load", duty[15:0], 0);
      n = 0;
      while (duty[15:0] != 16'd16 && n < 1100) begin @(negedge clk); n++; end
      chk("t2_wrap_load", duty[15:0], 16);
      hi = 0;
      for (int k = 0; k < PERIOD; k++) begin hi += int'(heater_pwm[0]); @(negedge clk); end
      chk("t2_high_ticks", hi, 16);

      // 3: large error clamps to PERIOD
      kp = 7'd127;
      set_sp(1600, 400);
      send(0, 0);
      chk("t3_hold", duty[15:0], 16);
      n = 0;
      while (duty[15:0] != 16'(PERIOD) && n < 1100) begin @(negedge clk); n++; end
      chk("t3_wrap_load", duty[15:0], PERIOD);
      hi = 0;
      for (int k = 0; k < PERIOD; k++) begin hi += int'(heater_pwm[0]); @(negedge clk); end
      chk("t3_high_ticks", hi, PERIOD);

      // samples still processed while disabled
      pid_en = 1'b0;
      send(0, 0);
      chk("dis_duty0", duty[15:0], 0);
      chk("dis_heater0", heater_pwm[0], 0);
      repeat (3) @(negedge clk);

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
